// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin over BCP engines, per-variable assignment
// table for duplicate/conflict filtering, one UC at a time to the Distribution_unit.
module uc_arbiter #(
  parameter int unsigned NUM_ENGINE      = 4,
  parameter int unsigned LIT_IDX_MAX     = 1024,
  parameter int unsigned VARIABLE_LENGTH = $clog2(LIT_IDX_MAX) + 1
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        start_in,
  input  logic [NUM_ENGINE-1:0]                       eng_uc_valid_in,
  input  logic [NUM_ENGINE-1:0][VARIABLE_LENGTH-1:0]  eng_uc_in,
  output logic [NUM_ENGINE-1:0]                       eng_uc_ack_out,
  input  logic [NUM_ENGINE-1:0]                       eng_idle_in,
  input  logic                                        dist_ready_in,
  output logic [VARIABLE_LENGTH-1:0]                  chosen_uc_out,
  output logic                                        chosen_uc_valid_out,
  output logic                                        conflict_out,
  output logic [VARIABLE_LENGTH-1:0]                  conflict_lit_out,
  output logic                                        done_out,
  output logic [VARIABLE_LENGTH-1:0]                  uc_count_out
);

  localparam int unsigned IDX_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int unsigned VAR_W = VARIABLE_LENGTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_CONFLICT,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           rr_q, rr_d;
  logic [VARIABLE_LENGTH-1:0] chosen_q, chosen_d;
  logic                       valid_q, valid_d;
  logic                       conflict_q, conflict_d;
  logic [VARIABLE_LENGTH-1:0] clit_q, clit_d;
  logic                       done_q, done_d;
  logic [VARIABLE_LENGTH-1:0] count_q, count_d;
  logic [NUM_ENGINE-1:0]      ack_c;

  logic [LIT_IDX_MAX-1:0]     asg_q;
  logic [LIT_IDX_MAX-1:0]     pol_q;
  logic                       tbl_set, tbl_clr;

  logic                       gnt_found;
  logic [IDX_W-1:0]           gnt_idx;
  logic [VARIABLE_LENGTH-1:0] gnt_lit;
  logic [VAR_W-1:0]           gnt_var;
  logic                       gnt_pol;

  // Round-robin search starting at rr_q (the slot after the last grant)
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < int'(NUM_ENGINE); k++) begin
      if (!gnt_found &&
          eng_uc_valid_in[IDX_W'((int'(rr_q) + k) % int'(NUM_ENGINE))]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'((int'(rr_q) + k) % int'(NUM_ENGINE));
      end
    end
  end

  assign gnt_lit = eng_uc_in[gnt_idx];
  assign gnt_var = gnt_lit[VAR_W-1:0];
  assign gnt_pol = gnt_lit[VARIABLE_LENGTH-1];

  // State register and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      chosen_q   <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      clit_q     <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      chosen_q   <= chosen_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      clit_q     <= clit_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  // Next-state, next-output and table control
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    chosen_d   = chosen_q;
    valid_d    = 1'b0;
    conflict_d = conflict_q;
    clit_d     = clit_q;
    done_d     = done_q;
    count_d    = count_q;
    ack_c      = '0;
    tbl_set    = 1'b0;
    tbl_clr    = 1'b0;

    if (start_in) begin
      state_d    = S_ARB;
      tbl_clr    = 1'b1;
      count_d    = '0;
      conflict_d = 1'b0;
      clit_d     = '0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_ARB: begin
          if (gnt_found) begin
            ack_c[gnt_idx] = 1'b1;
            rr_d = (gnt_idx == IDX_W'(NUM_ENGINE - 1)) ? '0 : gnt_idx + 1'b1;
            if (gnt_var == '0) begin
              state_d = S_ARB;
            end else if (!asg_q[gnt_var]) begin
              tbl_set  = 1'b1;
              chosen_d = gnt_lit;
              count_d  = (count_q == '1) ? count_q : count_q + 1'b1;
              valid_d  = 1'b1;
              state_d  = S_ISSUE;
            end else if (pol_q[gnt_var] != gnt_pol) begin
              conflict_d = 1'b1;
              clit_d     = gnt_lit;
              state_d    = S_CONFLICT;
            end
          end else if ((&eng_idle_in) && dist_ready_in) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_ISSUE: begin
          if (dist_ready_in) begin
            state_d = S_ARB;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Per-variable assignment table: assigned flag plus polarity
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asg_q <= '0;
      pol_q <= '0;
    end else if (tbl_clr) begin
      asg_q <= '0;
      pol_q <= '0;
    end else if (tbl_set) begin
      asg_q[gnt_var] <= 1'b1;
      pol_q[gnt_var] <= gnt_pol;
    end
  end

  // Ack is combinational so the engine sees it in the grant cycle itself
  assign eng_uc_ack_out      = ack_c;
  assign chosen_uc_out       = chosen_q;
  assign chosen_uc_valid_out = valid_q;
  assign conflict_out        = conflict_q;
  assign conflict_lit_out    = clit_q;
  assign done_out            = done_q;
  assign uc_count_out        = count_q;

endmodule

// File: tb/tb_uc_arbiter.sv
// Directed bench for uc_arbiter: arbitration order, stall, duplicates,
// conflicts, restart and asynchronous reset.
module tb_uc_arbiter;

  localparam int unsigned NE = 4;
  localparam int unsigned VL = 11;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start_in;
  logic [NE-1:0]          eng_uc_valid_in;
  logic [NE-1:0][VL-1:0]  eng_uc_in;
  logic [NE-1:0]          eng_uc_ack_out;
  logic [NE-1:0]          eng_idle_in;
  logic                   dist_ready_in;
  logic [VL-1:0]          chosen_uc_out;
  logic                   chosen_uc_valid_out;
  logic                   conflict_out;
  logic [VL-1:0]          conflict_lit_out;
  logic                   done_out;
  logic [VL-1:0]          uc_count_out;

  int checks = 0;
  int errors = 0;

  uc_arbiter #(.NUM_ENGINE(NE), .LIT_IDX_MAX(1024), .VARIABLE_LENGTH(VL)) dut (
    .clock               (clock),
    .reset               (reset),
    .start_in            (start_in),
    .eng_uc_valid_in     (eng_uc_valid_in),
    .eng_uc_in           (eng_uc_in),
    .eng_uc_ack_out      (eng_uc_ack_out),
    .eng_idle_in         (eng_idle_in),
    .dist_ready_in       (dist_ready_in),
    .chosen_uc_out       (chosen_uc_out),
    .chosen_uc_valid_out (chosen_uc_valid_out),
    .conflict_out        (conflict_out),
    .conflict_lit_out    (conflict_lit_out),
    .done_out            (done_out),
    .uc_count_out        (uc_count_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset           = 1'b0;
    start_in        = 1'b0;
    eng_uc_valid_in = '0;
    eng_uc_in       = '0;
    eng_idle_in     = '0;
    dist_ready_in   = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_valid",    32'(chosen_uc_valid_out), 32'h0);
    chk("rst_chosen",   32'(chosen_uc_out),       32'h0);
    chk("rst_conflict", 32'(conflict_out),        32'h0);
    chk("rst_clit",     32'(conflict_lit_out),    32'h0);
    chk("rst_done",     32'(done_out),            32'h0);
    chk("rst_count",    32'(uc_count_out),        32'h0);
    chk("rst_ack",      32'(eng_uc_ack_out),      32'h0);

    reset         = 1'b1;
    eng_idle_in   = 4'hF;
    dist_ready_in = 1'b1;
    step; step;
    chk("idle_no_done", 32'(done_out), 32'h0);

    // Empty round completes two edges after start
    start_in = 1'b1;
    step;
    start_in = 1'b0;
    chk("done_one_edge", 32'(done_out), 32'h0);
    step;
    chk("done_two_edges", 32'(done_out), 32'h1);
    chk("done_no_valid",  32'(chosen_uc_valid_out), 32'h0);

    // Four distinct literals, issued round-robin on alternate cycles
    start_in = 1'b1;
    step;
    start_in = 1'b0;
    chk("start_clears_done", 32'(done_out), 32'h0);
    eng_idle_in     = 4'h0;
    eng_uc_in[0]    = 11'h005;
    eng_uc_in[1]    = 11'h006;
    eng_uc_in[2]    = 11'h007;
    eng_uc_in[3]    = 11'h008;
    eng_uc_valid_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ack", 32'(eng_uc_ack_out), 32'(1 << i));
      step;
      eng_uc_valid_in[i] = 1'b0;
      chk("rr_valid",   32'(chosen_uc_valid_out), 32'h1);
      chk("rr_chosen",  32'(chosen_uc_out),       32'(5 + i));
      chk("rr_no_ack",  32'(eng_uc_ack_out),      32'h0);
      step;
    end
    chk("rr_count",    32'(uc_count_out),        32'h4);
    chk("rr_idle_arb", 32'(chosen_uc_valid_out), 32'h0);

    // Distribution unit stalls for five cycles
    dist_ready_in   = 1'b0;
    eng_uc_in[0]    = 11'h00A;
    eng_uc_valid_in = 4'b0001;
    #1;
    chk("stall_ack", 32'(eng_uc_ack_out), 32'h1);
    step;
    eng_uc_valid_in = 4'b0010;
    eng_uc_in[1]    = 11'h00B;
    repeat (5) begin
      chk("stall_valid",  32'(chosen_uc_valid_out), 32'h1);
      chk("stall_chosen", 32'(chosen_uc_out),       32'h00A);
      chk("stall_no_ack", 32'(eng_uc_ack_out),      32'h0);
      step;
    end
    dist_ready_in = 1'b1;
    #1;
    chk("issue_no_grant", 32'(eng_uc_ack_out), 32'h0);
    step;
    chk("xfer_valid_low", 32'(chosen_uc_valid_out), 32'h0);
    chk("next_grant",     32'(eng_uc_ack_out),      32'h2);
    step;
    eng_uc_valid_in = 4'b0000;
    chk("next_chosen", 32'(chosen_uc_out), 32'h00B);
    chk("next_count",  32'(uc_count_out),  32'h6);
    step;

    // Duplicate then conflicting implication of variable 3
    start_in = 1'b1;
    step;
    start_in = 1'b0;
    chk("round_count_clr", 32'(uc_count_out), 32'h0);
    eng_uc_in[1]    = 11'h003;
    eng_uc_valid_in = 4'b0010;
    #1;
    chk("v3_ack", 32'(eng_uc_ack_out), 32'h2);
    step;
    eng_uc_valid_in = 4'b0000;
    chk("v3_chosen", 32'(chosen_uc_out), 32'h003);
    chk("v3_count",  32'(uc_count_out),  32'h1);
    step;
    eng_uc_in[2]    = 11'h003;
    eng_uc_valid_in = 4'b0100;
    #1;
    chk("dup_ack", 32'(eng_uc_ack_out), 32'h4);
    step;
    eng_uc_valid_in = 4'b0000;
    chk("dup_no_issue", 32'(chosen_uc_valid_out), 32'h0);
    chk("dup_count",    32'(uc_count_out),        32'h1);
    eng_uc_in[3]    = 11'h403;
    eng_uc_valid_in = 4'b1000;
    #1;
    chk("cfl_ack", 32'(eng_uc_ack_out), 32'h8);
    step;
    chk("cfl_flag",  32'(conflict_out),        32'h1);
    chk("cfl_lit",   32'(conflict_lit_out),    32'h403);
    chk("cfl_valid", 32'(chosen_uc_valid_out), 32'h0);
    eng_uc_in[0]    = 11'h010;
    eng_uc_valid_in = 4'b1001;
    repeat (2) begin
      #1;
      chk("cfl_no_ack", 32'(eng_uc_ack_out), 32'h0);
      step;
    end
    chk("cfl_held",    32'(conflict_out), 32'h1);
    chk("cfl_no_done", 32'(done_out),     32'h0);

    // Restart clears the table: 11'h403 now issues
    start_in = 1'b1;
    #1;
    chk("start_no_ack", 32'(eng_uc_ack_out), 32'h0);
    step;
    start_in        = 1'b0;
    eng_uc_valid_in = 4'b1000;
    chk("restart_cfl",  32'(conflict_out),     32'h0);
    chk("restart_clit", 32'(conflict_lit_out), 32'h0);
    #1;
    chk("restart_ack", 32'(eng_uc_ack_out), 32'h8);
    step;
    eng_uc_valid_in = 4'b0000;
    chk("restart_chosen", 32'(chosen_uc_out),       32'h403);
    chk("restart_valid",  32'(chosen_uc_valid_out), 32'h1);
    chk("restart_count",  32'(uc_count_out),        32'h1);
    step;

    // Variable index 0 is acked and dropped
    eng_uc_in[2]    = 11'h400;
    eng_uc_valid_in = 4'b0100;
    #1;
    chk("v0_ack", 32'(eng_uc_ack_out), 32'h4);
    step;
    eng_uc_valid_in = 4'b0000;
    chk("v0_no_issue", 32'(chosen_uc_valid_out), 32'h0);
    chk("v0_count",    32'(uc_count_out),        32'h1);

    // Asynchronous reset while a UC is pending
    dist_ready_in   = 1'b0;
    eng_uc_in[0]    = 11'h020;
    eng_uc_valid_in = 4'b0001;
    #1;
    chk("pre_rst_ack", 32'(eng_uc_ack_out), 32'h1);
    step;
    chk("pre_rst_valid",  32'(chosen_uc_valid_out), 32'h1);
    chk("pre_rst_chosen", 32'(chosen_uc_out),       32'h020);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(chosen_uc_valid_out), 32'h0);
    chk("arst_count", 32'(uc_count_out),        32'h0);
    chk("arst_ack",   32'(eng_uc_ack_out),      32'h0);
    @(negedge clock);
    reset = 1'b1;
    step;
    chk("post_rst_ack",   32'(eng_uc_ack_out),      32'h0);
    chk("post_rst_valid", 32'(chosen_uc_valid_out), 32'h0);
    chk("post_rst_done",  32'(done_out),            32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
